// File: rtl/ir_nec_transmitter.sv
// NEC IR transmitter: sends a leader, then addr/~addr/cmd/~cmd, then a stop burst (or the repeat code), then a gap.
// Define IR_NEC_TX_CARRIER_EN to modulate oIRLED with the carrier; otherwise oIRLED is the plain envelope.
module ir_nec_transmitter #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CARRIER_HZ = 38_000,
    parameter int UNIT_CYC   = 28125,
    parameter int GAP_UNITS  = 72
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iSend,
    input  logic       iRepeat,
    input  logic [7:0] iAddr,
    input  logic [7:0] iCmd,
    output logic       oBusy,
    output logic       oDone,
    output logic       oIRDA_n,
    output logic       oIRLED
);

    localparam int UW   = $clog2(UNIT_CYC);
    localparam int MAXU = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int NW   = $clog2(MAXU);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
    localparam logic [NW-1:0] GAP_LAST  = NW'(GAP_UNITS - 1);
    // An impossible configuration never leaves IDLE instead of producing a corrupt waveform.
    localparam bit CFG_OK = (UNIT_CYC >= 2) && (GAP_UNITS >= 1) && (CLK_HZ >= 2 * CARRIER_HZ);

    typedef enum logic [2:0] {
        IDLE, LEAD_B, LEAD_S, BIT_B, BIT_S, STOP_B, GAP
    } state_t;

    function automatic logic is_burst(input state_t s);
        return (s == LEAD_B) || (s == BIT_B) || (s == STOP_B);
    endfunction

    state_t        state_q, state_d;
    logic [UW-1:0] unit_q, unit_d;
    logic [NW-1:0] units_q, units_d;
    logic [NW-1:0] units_last;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   word_q, word_d;
    logic          rep_q, rep_d;
    logic          unit_end, state_end, accept;
    logic          busy_q, done_q, irda_n_q, led_q;
    logic          led_d;

    assign accept   = CFG_OK && (state_q == IDLE) && (iSend || iRepeat);
    assign unit_end = (unit_q == UNIT_LAST);

    always_comb begin
        units_last = '0;
        case (state_q)
            LEAD_B:  units_last = NW'(15);
            LEAD_S:  units_last = rep_q ? NW'(3) : NW'(7);
            BIT_S:   units_last = word_q[bit_q] ? NW'(2) : NW'(0);
            GAP:     units_last = GAP_LAST;
            default: units_last = '0;
        endcase
    end

    assign state_end = unit_end && (units_q == units_last);

    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        units_d = units_q;
        bit_d   = bit_q;
        word_d  = word_q;
        rep_d   = rep_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = LEAD_B;
                unit_d  = '0;
                units_d = '0;
                bit_d   = '0;
                word_d  = {~iCmd, iCmd, ~iAddr, iAddr};
                rep_d   = !iSend;
            end
        end else begin
            unit_d = unit_end ? '0 : unit_q + 1'b1;
            if (state_end) begin
                units_d = '0;
                case (state_q)
                    LEAD_B: state_d = LEAD_S;
                    LEAD_S: state_d = rep_q ? STOP_B : BIT_B;
                    BIT_B:  state_d = BIT_S;
                    BIT_S: begin
                        state_d = (bit_q == 5'd31) ? STOP_B : BIT_B;
                        bit_d   = bit_q + 5'd1;
                    end
                    STOP_B:  state_d = GAP;
                    default: state_d = IDLE;
                endcase
            end else if (unit_end) begin
                units_d = units_q + 1'b1;
            end
        end
    end

`ifdef IR_NEC_TX_CARRIER_EN
    localparam int HALF_CYC = CLK_HZ / (2 * CARRIER_HZ);
    localparam int CW = $clog2(HALF_CYC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] car_cnt_q, car_cnt_d;
    logic          car_ph_q, car_ph_d;

    // Burst states never follow one another, so a state change into a burst marks its first cycle.
    always_comb begin
        car_cnt_d = car_cnt_q;
        car_ph_d  = car_ph_q;
        if (is_burst(state_d) && (state_d != state_q)) begin
            car_cnt_d = '0;
            car_ph_d  = 1'b1;
        end else if (car_cnt_q == HALF_LAST) begin
            car_cnt_d = '0;
            car_ph_d  = !car_ph_q;
        end else begin
            car_cnt_d = car_cnt_q + 1'b1;
        end
    end

    assign led_d = is_burst(state_d) && car_ph_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_cnt_q <= '0;
            car_ph_q  <= 1'b0;
        end else begin
            car_cnt_q <= car_cnt_d;
            car_ph_q  <= car_ph_d;
        end
    end
`else
    assign led_d = is_burst(state_d);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            unit_q   <= '0;
            units_q  <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            rep_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irda_n_q <= 1'b1;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            units_q  <= units_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            rep_q    <= rep_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_q == GAP) && state_end;
            irda_n_q <= !is_burst(state_d);
            led_q    <= led_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oIRDA_n = irda_n_q;
    assign oIRLED  = led_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter with short units; expected waveforms come from the NEC pulse-distance rules.
module tb_ir_nec_transmitter;

    localparam int UNIT_CYC  = 4;
    localparam int GAP_UNITS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       iSend, iRepeat;
    logic [7:0] iAddr, iCmd;
    logic       oBusy, oDone, oIRDA_n, oIRLED;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    ir_nec_transmitter #(
        .CLK_HZ    (50_000_000),
        .CARRIER_HZ(38_000),
        .UNIT_CYC  (UNIT_CYC),
        .GAP_UNITS (GAP_UNITS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iSend  (iSend),
        .iRepeat(iRepeat),
        .iAddr  (iAddr),
        .iCmd   (iCmd),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oIRDA_n(oIRDA_n),
        .oIRLED (oIRLED)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {busy,done,irda_n,led}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: a list of envelope levels, one per clock, from the burst/space unit rules.
    task automatic push_level(input bit level, input int units);
        for (int i = 0; i < units * UNIT_CYC; i++) exp_q.push_back(level);
    endtask

    task automatic build(input bit rep, input logic [7:0] a, input logic [7:0] c);
        logic [31:0] w;
        exp_q.delete();
        w = {~c, c, ~a, a};
        push_level(1'b0, 16);
        push_level(1'b1, rep ? 4 : 8);
        if (!rep) begin
            for (int i = 0; i < 32; i++) begin
                push_level(1'b0, 1);
                push_level(1'b1, w[i] ? 3 : 1);
            end
        end
        push_level(1'b0, 1);
        push_level(1'b1, GAP_UNITS);
    endtask

    task automatic request(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c);
        @(posedge clk); #1;
        iSend = s; iRepeat = r; iAddr = a; iCmd = c;
        @(posedge clk); #1;
    endtask

    // Called at cycle 0 of a transfer; returns on the oDone cycle.
    task automatic run_frame(input string tag, input bit rep, input logic [7:0] a, input logic [7:0] c,
                             input bit hold, input bit poke);
        build(rep, a, c);
        if (!hold) begin
            iSend = 1'b0; iRepeat = 1'b0; iAddr = 8'($urandom); iCmd = 8'($urandom);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (poke && k == 150) begin
                iSend = 1'b1; iRepeat = 1'b1; iAddr = 8'($urandom); iCmd = 8'($urandom);
            end
            if (poke && k == 151) begin
                iSend = 1'b0; iRepeat = 1'b0;
            end
            chk(tag, {oBusy, oDone, oIRDA_n, oIRLED}, {1'b1, 1'b0, exp_q[k], ~exp_q[k]});
            @(posedge clk); #1;
        end
        chk({tag, "_done"}, {oBusy, oDone, oIRDA_n, oIRLED}, 4'b0110);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk(tag, {oBusy, oDone, oIRDA_n, oIRLED}, 4'b0010);
        end
    endtask

    initial begin
        logic [7:0] a, c;
        rst = 1'b1; iSend = 1'b0; iRepeat = 1'b0; iAddr = 8'h00; iCmd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {oBusy, oDone, oIRDA_n, oIRLED}, 4'b0010);
        rst = 1'b0;
        idle_check("idle_after_reset", 3);

        a = 8'($urandom); c = 8'($urandom);
        request(1'b0, 1'b1, a, c);
        run_frame("repeat_first", 1'b1, a, c, 1'b0, 1'b0);
        idle_check("idle_after_repeat", 2);

        request(1'b1, 1'b0, 8'h00, 8'h5A);
        run_frame("frame_00_5A", 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0);
        idle_check("idle_after_frame", 2);

        for (int n = 0; n < 3; n++) begin
            a = 8'($urandom); c = 8'($urandom);
            request(1'b1, 1'b0, a, c);
            run_frame("frame_rand", 1'b0, a, c, 1'b0, n == 1);
        end

        a = 8'($urandom); c = 8'($urandom);
        request(1'b1, 1'b1, a, c);
        run_frame("priority", 1'b0, a, c, 1'b0, 1'b0);
        idle_check("idle_after_priority", 1);

        a = 8'($urandom); c = 8'($urandom);
        request(1'b1, 1'b0, a, c);
        run_frame("held_first", 1'b0, a, c, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_frame("held_second", 1'b0, a, c, 1'b0, 1'b0);

        a = 8'($urandom); c = 8'($urandom);
        request(1'b0, 1'b1, a, c);
        run_frame("repeat_again", 1'b1, a, c, 1'b0, 1'b0);

        // Cycle 101 of a frame lies in the first BIT_S (leader is 96 cycles, BIT_B 4).
        request(1'b1, 1'b0, 8'h00, 8'h5A);
        iSend = 1'b0;
        repeat (101) @(posedge clk);
        #2;
        chk("pre_reset_bit_s", {oBusy, oDone, oIRDA_n, oIRLED}, 4'b1010);
        rst = 1'b1;
        #1;
        chk("async_reset", {oBusy, oDone, oIRDA_n, oIRLED}, 4'b0010);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        idle_check("no_done_after_reset", 12);

        a = 8'($urandom); c = 8'($urandom);
        request(1'b1, 1'b0, a, c);
        run_frame("frame_after_reset", 1'b0, a, c, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
